dsp_arbiter: RTL and testbench
==============================

DSP_ARBITER -- requirements
Module: dsp_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, the number of cycles to wait for each dsp_ack phase before aborting.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on posedge clk.
REQ-003 SHALL have port reset, input, 1, the reset; it is synchronous and active-high.
REQ-004 SHALL have port req0_valid, input, 1: requester 0 (CPU display path) has a character.
REQ-005 SHALL have port req0_data, input, 7, the requester 0 ASCII character.
REQ-006 SHALL have port req0_ready, output, 1: the arbiter accepts the requester 0 character this cycle.
REQ-007 SHALL have ports req1_valid (input, 1), req1_data (input, 7) and req1_ready (output, 1), which behave the same as the requester 0 ports for requester 1 (banner/debug echo).
REQ-008 SHALL have port dsp_rdy, output, 1: a character is presented to the display terminal.
REQ-009 SHALL have port dsp_ack, input, 1, the terminal acknowledge; it is already synchronous to clk.
REQ-010 SHALL have port dsp_data, output, 7, the ASCII character presented to the terminal.
REQ-011 SHALL have port owner, output, 1, the index of the requester whose character is in flight.
REQ-012 SHALL have port busy, output, 1: the state is not sIdle.
REQ-013 SHALL have port timeout_err, output, 1, a sticky abort flag.

Function
REQ-014 SHALL implement a one-hot FSM with three states: sIdle, sAck0 (wait for dsp_ack high) and sAck1 (wait for dsp_ack low).
REQ-015 SHALL drive reqN_ready = (state==sIdle) && !dsp_ack && grant==N; a transfer is reqN_valid && reqN_ready in the same cycle.
REQ-016 SHALL use this grant rule:
- Only one valid requester: grant that requester.
- Both valid: grant the requester not in last_grant.
- last_grant updates on each transfer.
REQ-017 SHALL, on a transfer, register dsp_data <= reqN_data, owner <= N, dsp_rdy <= 1, state <= sAck0; dsp_rdy is therefore high the cycle after the transfer.
REQ-018 SHALL, in sAck0 with dsp_ack==1, go to sAck1; otherwise it stays in sAck0.
REQ-019 SHALL, in sAck1 with dsp_ack==0, set dsp_rdy <= 0 and go to sIdle; otherwise it stays in sAck1.
REQ-020 SHALL hold dsp_data and owner stable from the cycle dsp_rdy rises through the cycle dsp_rdy falls.
REQ-021 SHALL accept at most one character per four-phase handshake, and dsp_rdy SHALL be low for at least one cycle between characters.
REQ-022 SHALL keep both ready outputs low while dsp_ack is high in sIdle (stale acknowledge), so no character is accepted.
REQ-023 SHALL ignore valid-low and data changes during sAck0/sAck1; a requester holding valid waits without loss.
REQ-024 SHALL, on reset asserted mid-handshake, abandon the in-flight character (dropped, not replayed) and apply the reset values on the next edge.
REQ-025 SHALL force any illegal state encoding to sIdle with dsp_rdy <= 0 on the next edge.

Reset
REQ-026 SHALL set these reset values:
- state = sIdle.
- dsp_rdy = 0, dsp_data = 7'h00, owner = 0.
- last_grant = 1, so requester 0 wins the first contention.
- timeout_err = 0, timeout counter = 0.
REQ-027 SHALL hold req0_ready and req1_ready low for the whole cycle reset is sampled high.

Configuration
REQ-028 SHALL, with DSP_ARB_TIMEOUT_EN defined, implement the timeout watchdog:
- A 16-bit counter clears on entry to sAck0 or sAck1 and increments each cycle in those states.
- When the counter reaches TIMEOUT_CYCLES-1 without the awaited dsp_ack level: dsp_rdy <= 0, state <= sIdle, timeout_err <= 1.
- timeout_err is sticky until reset; the character is dropped.
REQ-029 SHALL, with DSP_ARB_TIMEOUT_EN undefined, omit the counter, tie timeout_err to 0, and wait in sAck0/sAck1 indefinitely.

Structure
REQ-030 SHALL take the state encodings (sIdle=3'b001, sAck0=3'b010, sAck1=3'b100) and the default TIMEOUT_CYCLES from shared package dsp_arb_pkg; the PIA and terminal-model blocks use the same package.
REQ-031 SHALL place the two-way round-robin grant logic (inputs: valid[1:0], last_grant, enable; output: grant) in sub-module rr_arb2.

Verification
REQ-032 SHALL pass a single-character test: req0 sends 0x41; the terminal model raises ack 3 cycles after dsp_rdy and drops it 2 cycles after that. Required: dsp_rdy high one cycle after transfer, dsp_data=0x41, owner=0, dsp_rdy low one cycle after ack falls.
REQ-033 SHALL pass a contention test: both requesters hold valid with req0=0x30 and req1=0x31 for 4 characters. Required order: 0x30, 0x31, 0x30, 0x31.
REQ-034 SHALL pass a stale-ack test: dsp_ack held high in sIdle for 5 cycles with req1 valid. Required: req1_ready stays 0 until the cycle after ack falls.
REQ-035 SHALL pass a reset-mid-handshake test: synchronous reset asserted in sAck1. Required: next cycle dsp_rdy=0, busy=0, dsp_data=0; after reset, req0 wins contention.
REQ-036 SHALL pass a timeout test (DSP_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8): no ack after char 0x5A. Required: dsp_rdy falls 8 cycles after entering sAck0, timeout_err=1 and stays 1, the next character is accepted normally.
REQ-037 SHALL pass a no-timeout test (DSP_ARB_TIMEOUT_EN undefined): same stimulus as REQ-036. Required: dsp_rdy stays high for 1000 cycles, timeout_err=0.

Source files
------------

// File: rtl/dsp_arb_pkg.sv
// Shared state encodings, character type and timeout default for the display
// arbiter and the blocks that talk to the display terminal.
package dsp_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_ACK0 = 3'b010,
    S_ACK1 = 3'b100
  } dsp_state_e;

  localparam int unsigned CHAR_W = 7;
  typedef logic [CHAR_W-1:0] char_t;

  localparam logic [15:0] TIMEOUT_CYCLES_DEF = 16'd50000;

endpackage

// File: rtl/dsp_arbiter_rr_arb2.sv
// Two-way round-robin grant, combinational: a lone requester wins, and under
// contention the requester not granted last time wins. Holds last_grant when disabled.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic       grant
);

  always_comb begin
    grant = last_grant;
    if (enable) begin
      case (valid)
        2'b01:   grant = 1'b0;
        2'b10:   grant = 1'b1;
        default: grant = ~last_grant;
      endcase
    end
  end

endmodule

// File: rtl/dsp_arbiter.sv
// Two-requester arbiter feeding a 4-phase display handshake; dsp_rdy rises the cycle after a
// transfer, one char per handshake. Optional ack watchdog under DSP_ARB_TIMEOUT_EN.
module dsp_arbiter
  import dsp_arb_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [6:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [6:0]  req1_data,
  output logic        req1_ready,
  output logic        dsp_rdy,
  input  logic        dsp_ack,
  output logic [6:0]  dsp_data,
  output logic        owner,
  output logic        busy,
  output logic        timeout_err
);

  dsp_state_e state_q, state_d;
  logic       dsp_rdy_q, dsp_rdy_d;
  char_t      dsp_data_q, dsp_data_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;

  logic arb_en;
  logic grant;
  logic xfer;

  // A stale acknowledge left high by the terminal must not start a new character.
  assign arb_en = (state_q == S_IDLE) && !dsp_ack && !reset;

  rr_arb2 u_rr_arb2 (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .grant      (grant)
  );

  assign req0_ready = arb_en && !grant;
  assign req1_ready = arb_en && grant;
  assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

`ifdef DSP_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TIMEOUT_CYCLES - 16'd1);
`endif

  always_comb begin
    state_d      = state_q;
    dsp_rdy_d    = dsp_rdy_q;
    dsp_data_d   = dsp_data_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
`ifdef DSP_ARB_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          dsp_data_d   = grant ? req1_data : req0_data;
          owner_d      = grant;
          last_grant_d = grant;
          dsp_rdy_d    = 1'b1;
          state_d      = S_ACK0;
`ifdef DSP_ARB_TIMEOUT_EN
          tmo_cnt_d    = '0;
`endif
        end
      end
      S_ACK0: begin
        if (dsp_ack) begin
          state_d = S_ACK1;
`ifdef DSP_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
`ifdef DSP_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d       = S_IDLE;
          dsp_rdy_d     = 1'b0;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end
      S_ACK1: begin
        if (!dsp_ack) begin
          state_d   = S_IDLE;
          dsp_rdy_d = 1'b0;
        end
`ifdef DSP_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d       = S_IDLE;
          dsp_rdy_d     = 1'b0;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end
      default: begin
        state_d   = S_IDLE;
        dsp_rdy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dsp_rdy_q    <= 1'b0;
      dsp_data_q   <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      dsp_rdy_q    <= dsp_rdy_d;
      dsp_data_q   <= dsp_data_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef DSP_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign timeout_err = 1'b0;
`endif

  assign dsp_rdy  = dsp_rdy_q;
  assign dsp_data = dsp_data_q;
  assign owner    = owner_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dsp_arbiter.sv
// Directed bench for dsp_arbiter: single char, contention, stale ack, reset mid-handshake,
// and watchdog behaviour (abort or indefinite wait depending on DSP_ARB_TIMEOUT_EN).
module tb_dsp_arbiter;

  logic       clk;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [6:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       dsp_rdy, dsp_ack;
  logic [6:0] dsp_data;
  logic       owner, busy, timeout_err;

  int n_vec  = 0;
  int n_miss = 0;

  dsp_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .dsp_rdy     (dsp_rdy),
    .dsp_ack     (dsp_ack),
    .dsp_data    (dsp_data),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Terminal model: ack rises 3 cycles after dsp_rdy, falls 2 cycles later.
  // Entered one tick after the transfer edge.
  task automatic serve(input logic [6:0] d, input logic o);
    repeat (3) step();
    dsp_ack = 1'b1;
    repeat (2) step();
    check_eq("hold_rdy", {31'd0, dsp_rdy}, 32'd1);
    check_eq("hold_data", {25'd0, dsp_data}, {25'd0, d});
    check_eq("hold_owner", {31'd0, owner}, {31'd0, o});
    dsp_ack = 1'b0;
    step();
    check_eq("rdy_fall", {31'd0, dsp_rdy}, 32'd0);
    check_eq("idle_after", {31'd0, busy}, 32'd0);
  endtask

  logic [6:0] exp_chr[4];
  int         low_cnt;

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 7'h00;
    req1_data  = 7'h00;
    dsp_ack    = 1'b0;

    // Reset: readies low while reset sampled, then reset values.
    @(negedge clk);
    check_eq("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    check_eq("rst_rdy1", {31'd0, req1_ready}, 32'd0);
    step();
    check_eq("rst_dsp_rdy", {31'd0, dsp_rdy}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_data", {25'd0, dsp_data}, 32'd0);
    check_eq("rst_owner", {31'd0, owner}, 32'd0);
    check_eq("rst_tmo", {31'd0, timeout_err}, 32'd0);
    reset      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Single character from requester 0.
    req0_valid = 1'b1;
    req0_data  = 7'h41;
    @(negedge clk);
    check_eq("single_ready", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    check_eq("single_rdy", {31'd0, dsp_rdy}, 32'd1);
    check_eq("single_data", {25'd0, dsp_data}, 32'h41);
    check_eq("single_owner", {31'd0, owner}, 32'd0);
    serve(7'h41, 1'b0);

    // Stale ack in idle with req1 waiting.
    dsp_ack    = 1'b1;
    req1_valid = 1'b1;
    req1_data  = 7'h52;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stale_rdy1", {31'd0, req1_ready}, 32'd0);
      check_eq("stale_busy", {31'd0, busy}, 32'd0);
      step();
    end
    dsp_ack = 1'b0;
    @(negedge clk);
    check_eq("stale_release", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    check_eq("stale_data", {25'd0, dsp_data}, 32'h52);
    check_eq("stale_owner", {31'd0, owner}, 32'd1);
    serve(7'h52, 1'b1);

    // Reset while in the ack-low phase; req0 was granted last.
    req0_valid = 1'b1;
    req0_data  = 7'h44;
    step();
    req0_valid = 1'b0;
    check_eq("mid_data", {25'd0, dsp_data}, 32'h44);
    repeat (3) step();
    dsp_ack = 1'b1;
    step();
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    check_eq("mid_rst_rdy", {31'd0, dsp_rdy}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_data", {25'd0, dsp_data}, 32'd0);
    reset   = 1'b0;
    dsp_ack = 1'b0;

    // Contention: req0 must win first after reset, then alternate.
    exp_chr[0] = 7'h30; exp_chr[1] = 7'h31; exp_chr[2] = 7'h30; exp_chr[3] = 7'h31;
    req0_valid = 1'b1; req0_data = 7'h30;
    req1_valid = 1'b1; req1_data = 7'h31;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("cont_rdy", {31'd0, dsp_rdy}, 32'd1);
      check_eq("cont_data", {25'd0, dsp_data}, {25'd0, exp_chr[i]});
      check_eq("cont_owner", {31'd0, owner}, i[31:0] & 32'd1);
      serve(exp_chr[i], i[0]);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // No ack after 0x5A.
    req0_valid = 1'b1;
    req0_data  = 7'h5A;
    step();
    req0_valid = 1'b0;
    check_eq("tmo_start", {31'd0, dsp_rdy}, 32'd1);
`ifdef DSP_ARB_TIMEOUT_EN
    repeat (7) step();
    check_eq("tmo_before", {31'd0, dsp_rdy}, 32'd1);
    check_eq("tmo_err_before", {31'd0, timeout_err}, 32'd0);
    step();
    check_eq("tmo_fall", {31'd0, dsp_rdy}, 32'd0);
    check_eq("tmo_idle", {31'd0, busy}, 32'd0);
    check_eq("tmo_err", {31'd0, timeout_err}, 32'd1);
    req1_valid = 1'b1;
    req1_data  = 7'h61;
    step();
    req1_valid = 1'b0;
    check_eq("tmo_next_data", {25'd0, dsp_data}, 32'h61);
    check_eq("tmo_next_owner", {31'd0, owner}, 32'd1);
    serve(7'h61, 1'b1);
    check_eq("tmo_sticky", {31'd0, timeout_err}, 32'd1);
`else
    low_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (!dsp_rdy || timeout_err) low_cnt++;
    end
    check_eq("notmo_hold", low_cnt, 32'd0);
    check_eq("notmo_err", {31'd0, timeout_err}, 32'd0);
    check_eq("notmo_data", {25'd0, dsp_data}, 32'h5A);
    serve(7'h5A, 1'b0);
    check_eq("notmo_err_end", {31'd0, timeout_err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
